// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: issue-side and result-side handshake bundle for alu_ctrl_pipe.
// Rev 1.0
`default_nettype none

interface alu_ctrl_pipe_if #(
  parameter int INSTR_W  = 32,
  parameter int CTRL_W   = 4,
  parameter int ERRCNT_W = 8
) ();
  logic                in_valid;
  logic                in_ready;
  logic [INSTR_W-1:0]  In;
  logic [1:0]          ALUOp;
  logic                out_valid;
  logic                out_ready;
  logic [CTRL_W-1:0]   Out;
  logic                MulDiv;
  logic                Illegal;
  logic                Busy;
  logic [ERRCNT_W-1:0] ErrCount;

  modport master (
    output in_valid, In, ALUOp, out_ready,
    input  in_ready, out_valid, Out, MulDiv, Illegal, Busy, ErrCount
  );

  modport slave (
    input  in_valid, In, ALUOp, out_ready,
    output in_ready, out_valid, Out, MulDiv, Illegal, Busy, ErrCount
  );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered MIPS ALU control decode with valid/ready, saturating illegal-op
// counter and optional mult/div hold enabled by ALU_CTRL_MULDIV_EN. Rev 1.0
`default_nettype none

module alu_ctrl_pipe #(
  parameter int INSTR_W  = 32,
  parameter int CTRL_W   = 4,
  parameter int MUL_LAT  = 4,
  parameter int DIV_LAT  = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_ctrl_pipe_if.slave    bus
);

  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MULT = 4'b1000;
  localparam logic [3:0] C_DIV  = 4'b1001;

  logic [5:0] w_funct;
  logic [5:0] w_opcode;
  logic [3:0] w_code;
  logic       w_muldiv;
  logic       w_illegal;
  logic       w_accept;
  logic       w_busy;
  logic       w_unused;

  assign w_funct  = bus.In[5:0];
  assign w_opcode = bus.In[31:26];
  assign w_unused = ^bus.In;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_code    = C_ADD;
    w_muldiv  = 1'b0;
    w_illegal = 1'b0;
    case (bus.ALUOp)
      2'b00: w_code = C_ADD;
      2'b01: w_code = C_SUB;
      2'b10: begin
        case (w_funct)
          6'b100000: w_code = C_ADD;
          6'b100010: w_code = C_SUB;
          6'b100100: w_code = C_AND;
          6'b100101: w_code = C_OR;
          6'b100111: w_code = C_NOR;
          6'b101010: w_code = C_SLT;
`ifdef ALU_CTRL_MULDIV_EN
          6'b011000: begin
            w_code   = C_MULT;
            w_muldiv = 1'b1;
          end
          6'b011010: begin
            w_code   = C_DIV;
            w_muldiv = 1'b1;
          end
`endif
          default: begin
            w_code    = C_ADD;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        case (w_opcode)
          6'b001000: w_code = C_ADD;
          6'b001100: w_code = C_AND;
          6'b001101: w_code = C_OR;
          6'b001010: w_code = C_SLT;
          default: begin
            w_code    = C_ADD;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------- handshake
  logic                out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]   out_q,       out_d;
  logic                illegal_q,   illegal_d;
  logic [ERRCNT_W-1:0] errcnt_q,    errcnt_d;

  assign bus.in_ready = !w_busy && (!out_valid_q || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;

  // ---------------------------------------------------------------- mult/div hold
`ifdef ALU_CTRL_MULDIV_EN
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               muldiv_q, muldiv_d;
  logic               w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_accept && w_muldiv) begin
          state_d = S_BUSY;
          cnt_d   = (w_code == C_MULT) ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1);
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (cnt_q == '0) begin
          w_done  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    muldiv_d = muldiv_q;
    if (w_accept) begin
      muldiv_d = w_muldiv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muldiv_q <= 1'b0;
    end else begin
      muldiv_q <= muldiv_d;
    end
  end

  assign bus.MulDiv = muldiv_q;
`else
  assign w_busy     = 1'b0;
  assign bus.MulDiv = 1'b0;
`endif

  // ---------------------------------------------------------------- result registers
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    illegal_d   = illegal_q;
    errcnt_d    = errcnt_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_accept) begin
      out_d       = CTRL_W'(w_code);
      illegal_d   = w_illegal;
      // mult/div results only become valid when the hold finishes
      out_valid_d = !w_muldiv;
      if (w_illegal && (errcnt_q != '1)) begin
        errcnt_d = errcnt_q + ERRCNT_W'(1);
      end
    end
`ifdef ALU_CTRL_MULDIV_EN
    if (w_done) begin
      out_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      illegal_q   <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      illegal_q   <= illegal_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Out       = out_q;
  assign bus.Illegal   = illegal_q;
  assign bus.Busy      = w_busy;
  assign bus.ErrCount  = errcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed vectors with literal checks plus a per-cycle reference model.
// Rev 1.0
`default_nettype none

module tb_alu_ctrl_pipe;

  localparam int INSTR_W  = 32;
  localparam int CTRL_W   = 4;
  localparam int MUL_LAT  = 4;
  localparam int DIV_LAT  = 16;
  localparam int ERRCNT_W = 2;
  localparam int ERR_MAX  = (1 << ERRCNT_W) - 1;
`ifdef ALU_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_pipe_if #(.INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .ERRCNT_W(ERRCNT_W)) bus_if ();

  alu_ctrl_pipe #(
    .INSTR_W (INSTR_W),
    .CTRL_W  (CTRL_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: results as the spec tables define them, latency as edge countdown.
  function automatic void ref_decode(input logic [1:0] op, input logic [31:0] ins,
                                     output logic [3:0] code, output bit md, output bit ill);
    code = 4'b0010; md = 1'b0; ill = 1'b0;
    if (op == 2'b00) code = 4'b0010;
    else if (op == 2'b01) code = 4'b0110;
    else if (op == 2'b10) begin
      case (ins[5:0])
        6'b100000: code = 4'b0010;
        6'b100010: code = 4'b0110;
        6'b100100: code = 4'b0000;
        6'b100101: code = 4'b0001;
        6'b100111: code = 4'b1100;
        6'b101010: code = 4'b0111;
        6'b011000: if (MD_EN) begin code = 4'b1000; md = 1'b1; end else ill = 1'b1;
        6'b011010: if (MD_EN) begin code = 4'b1001; md = 1'b1; end else ill = 1'b1;
        default:   ill = 1'b1;
      endcase
    end else begin
      case (ins[31:26])
        6'b001000: code = 4'b0010;
        6'b001100: code = 4'b0000;
        6'b001101: code = 4'b0001;
        6'b001010: code = 4'b0111;
        default:   ill = 1'b1;
      endcase
    end
  endfunction

  bit         m_ov, m_md, m_ill, m_rdy, m_acc, t_md, t_ill;
  logic [3:0] m_out, t_code;
  int         m_err, m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov = 0; m_out = 0; m_md = 0; m_ill = 0; m_err = 0; m_left = 0;
    end else begin
      m_rdy = (m_left == 0) && (!m_ov || bus_if.out_ready);
      m_acc = bus_if.in_valid && m_rdy;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_ov = 1;
      end else begin
        if (m_ov && bus_if.out_ready) m_ov = 0;
        if (m_acc) begin
          ref_decode(bus_if.ALUOp, bus_if.In, t_code, t_md, t_ill);
          m_out = t_code; m_md = t_md; m_ill = t_ill;
          if (t_ill && m_err < ERR_MAX) m_err++;
          if (t_md) begin
            m_left = (t_code == 4'b1000) ? MUL_LAT : DIV_LAT;
            m_ov   = 0;
          end else begin
            m_ov = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", bus_if.in_ready, 1);
      chk("rst_out_valid", bus_if.out_valid, 0);
      chk("rst_busy", bus_if.Busy, 0);
      chk("rst_errcount", bus_if.ErrCount, 0);
      chk("rst_out", bus_if.Out, 0);
    end else begin
      chk("m_in_ready", bus_if.in_ready, (m_left == 0) && (!m_ov || bus_if.out_ready));
      chk("m_out_valid", bus_if.out_valid, m_ov);
      chk("m_busy", bus_if.Busy, m_left > 0);
      chk("m_errcount", bus_if.ErrCount, m_err);
      if (m_ov) begin
        chk("m_out", bus_if.Out, m_out);
        chk("m_muldiv", bus_if.MulDiv, m_md);
        chk("m_illegal", bus_if.Illegal, m_ill);
      end
    end
  end

  // Holds the op until an edge at which in_ready was high; returns at that edge + 1.
  task automatic send(input logic [1:0] op, input logic [31:0] ins);
    bit r;
    int n;
    r = 0;
    n = 0;
    bus_if.in_valid = 1'b1;
    bus_if.ALUOp    = op;
    bus_if.In       = ins;
    do begin
      @(negedge clk);
      r = bus_if.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, bus_if.in_ready, 1);
    chk({tag, "_out_valid"}, bus_if.out_valid, 0);
    chk({tag, "_out"}, bus_if.Out, 0);
    chk({tag, "_muldiv"}, bus_if.MulDiv, 0);
    chk({tag, "_illegal"}, bus_if.Illegal, 0);
    chk({tag, "_busy"}, bus_if.Busy, 0);
    chk({tag, "_errcount"}, bus_if.ErrCount, 0);
  endtask

  logic [5:0] fun_v[6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
  logic [3:0] fun_e[6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
  logic [1:0] err_e[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.In        = '0;
    bus_if.ALUOp     = 2'b00;
    bus_if.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      send(2'b10, {26'h0, fun_v[i]});
      chk($sformatf("funct%0d_out", i), bus_if.Out, fun_e[i]);
      chk($sformatf("funct%0d_valid", i), bus_if.out_valid, 1);
      chk($sformatf("funct%0d_illegal", i), bus_if.Illegal, 0);
    end

    send(2'b11, {6'b001101, 26'h0});
    chk("ori_out", bus_if.Out, 4'b0001);
    send(2'b00, 32'hFFFF_FFFF);
    chk("aluop00_out", bus_if.Out, 4'b0010);
    send(2'b01, 32'h0);
    chk("aluop01_out", bus_if.Out, 4'b0110);

    send(2'b10, 32'h0000_0018);
    if (MD_EN) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          @(posedge clk);
          #1;
        end
        chk($sformatf("mult_busy%0d", k), bus_if.Busy, 1);
        chk($sformatf("mult_in_ready%0d", k), bus_if.in_ready, 0);
        chk($sformatf("mult_valid%0d", k), bus_if.out_valid, 0);
      end
      @(posedge clk);
      #1;
      chk("mult_valid", bus_if.out_valid, 1);
      chk("mult_out", bus_if.Out, 4'b1000);
      chk("mult_muldiv", bus_if.MulDiv, 1);
      chk("mult_busy_end", bus_if.Busy, 0);
    end else begin
      chk("mult_off_out", bus_if.Out, 4'b0010);
      chk("mult_off_illegal", bus_if.Illegal, 1);
      chk("mult_off_muldiv", bus_if.MulDiv, 0);
    end

    send(2'b00, 32'h0);
    bus_if.out_ready = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.ALUOp     = 2'b01;
    bus_if.In        = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_out", k), bus_if.Out, 4'b0010);
      chk($sformatf("stall%0d_in_ready", k), bus_if.in_ready, 0);
    end
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    chk("drain_accept_out", bus_if.Out, 4'b0110);
    chk("drain_accept_valid", bus_if.out_valid, 1);

    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      send(2'b10, 32'h0000_003F);
      chk($sformatf("ill%0d_out", i), bus_if.Out, 4'b0010);
      chk($sformatf("ill%0d_flag", i), bus_if.Illegal, 1);
      chk($sformatf("ill%0d_errcount", i), bus_if.ErrCount, err_e[i]);
    end

    send(2'b10, 32'h0000_001A);
    repeat (5) @(posedge clk);
    #2;
    if (MD_EN) chk("div_busy", bus_if.Busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b11, {6'b001000, 26'h0});
    chk("post_rst_valid", bus_if.out_valid, 1);
    chk("post_rst_out", bus_if.Out, 4'b0010);
    send(2'b11, {6'b001100, 26'h0});
    chk("andi_out", bus_if.Out, 4'b0000);
    send(2'b11, {6'b001010, 26'h0});
    chk("slti_out", bus_if.Out, 4'b0111);
    send(2'b11, {6'b000000, 26'h20});
    chk("bad_opcode_illegal", bus_if.Illegal, 1);
    chk("bad_opcode_out", bus_if.Out, 4'b0010);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, parametrised ALU control stage for the MIPS datapath: decodes a 2-bit ALUOp plus the instruction word into a 4-bit ALU control code. It adds an immediate-opcode decode mode, a valid/ready handshake on both sides, illegal-encoding detection with a saturating error counter, and multi-cycle hold for mult/div. It sits between instruction decode and the ALU/multiplier issue logic.

## Interface
- INSTR_W, 32, instruction width; must be at least 32.
- CTRL_W, 4, control code width; must be at least 4, and upper bits above [3:0] are driven 0.
- MUL_LAT, 4, cycles from accept to out_valid for mult; must be at least 1.
- DIV_LAT, 16, cycles from accept to out_valid for div; must be at least 1.
- ERRCNT_W, 8, width of ErrCount.

- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  In/ALUOp valid.
- in_ready  out  1  stage can accept.
- In  in  INSTR_W  instruction word; funct is In[5:0], opcode is In[31:26].
- ALUOp  in  2  decode mode.
- out_valid  out  1  Out/flags valid.
- out_ready  in  1  consumer accepts.
- Out  out  CTRL_W  ALU control code.
- MulDiv  out  1  Out is a mult/div code.
- Illegal  out  1  encoding not recognised.
- Busy  out  1  mult/div hold in progress.
- ErrCount  out  ERRCNT_W  accepted illegal encodings, saturating.

## Operation
- Decode by ALUOp:
  - 00 → 0010 (add: lw/sw).
  - 01 → 0110 (sub: beq).
  - 10 → funct decode.
  - 11 → opcode decode.
- Funct decode:
  - 100000 → 0010 (add); 100010 → 0110 (sub).
  - 100100 → 0000 (and); 100101 → 0001 (or).
  - 100111 → 1100 (nor); 101010 → 0111 (slt).
  - 011000 → 1000 (mult, MulDiv=1); 011010 → 1001 (div, MulDiv=1).
- Opcode decode:
  - 001000 → 0010 (addi); 001100 → 0000 (andi).
  - 001101 → 0001 (ori); 001010 → 0111 (slti).
- Any other encoding → Out=0010, Illegal=1, MulDiv=0.
- Accept: in_valid && in_ready at a rising edge. Out, MulDiv and Illegal are registered on accept and held until drained.
- in_ready = !Busy && (!out_valid || out_ready). Accept and drain in the same cycle is allowed, giving a throughput of 1/cycle for non-mult/div ops.
- Drain: out_valid && out_ready at an edge clears out_valid, unless a new accept occurs at the same edge.
- ErrCount increments by 1 on each accepted Illegal op and saturates at all-ones; it never wraps.
- FSM states:
  - IDLE:
    - Accept of a non-mult/div op → out_valid=1 next cycle.
    - Accept of mult/div → BUSY; cnt loaded with MUL_LAT-1 or DIV_LAT-1; out_valid=0.
  - BUSY: Busy=1, in_ready=0.
    - If cnt==0 at an edge → out_valid=1, go to IDLE.
    - Otherwise cnt decrements.
  - The counter width covers the larger of MUL_LAT-1 and DIV_LAT-1.
- Asserting rst_n low mid-operation aborts any hold immediately: the FSM returns to IDLE and the pending result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, Out=0, MulDiv=0, Illegal=0, Busy=0, ErrCount=0, FSM=IDLE, cnt=0.
- Non-mult/div latency: out_valid rises at the edge that accepts the op (1 cycle).
- Mult latency: out_valid rises MUL_LAT edges after the accepting edge. Div latency is the same with DIV_LAT.
- Busy is high from the accepting edge until the edge at which out_valid rises.
- Out is stable while out_valid=1 and out_ready=0.
- in_ready is combinational from out_ready, Busy and out_valid only; it does not depend on in_valid.
- In and ALUOp are sampled only on accept and ignored otherwise.

## Configuration
- ALU_CTRL_MULDIV_EN defined: mult/div decode as specified, with the BUSY hold.
- ALU_CTRL_MULDIV_EN undefined:
  - funct 011000 and 011010 decode as Illegal.
  - The FSM, counter and MUL_LAT/DIV_LAT logic are not built.
  - Busy is tied 0 and MulDiv is tied 0.

## Test plan
- Reset release, then ALUOp=10 with funct 100000, 100010, 100100, 100101, 100111, 101010 back-to-back with out_ready=1 → Out = 0010, 0110, 0000, 0001, 1100, 0111 on 6 consecutive cycles, Illegal=0 throughout.
- ALUOp=11 with opcode 001101, then ALUOp=00, then ALUOp=01 → Out = 0001, 0010, 0110.
- MULDIV_EN defined, MUL_LAT=4, funct 011000 → Busy=1 and in_ready=0 for 4 cycles; out_valid rises 4 edges after accept with Out=1000, MulDiv=1.
- out_ready=0 held for 3 cycles with a valid result → Out stable, in_ready=0, a second in_valid is not accepted; out_ready=1 → drain and accept occur at the same edge.
- ERRCNT_W=2, 5 accepted illegal funct 111111 → Out=0010, Illegal=1 each time; ErrCount reads 1, 2, 3, 3, 3.
- DIV_LAT=16, rst_n pulsed low 5 cycles after a div accept → all outputs return to reset values asynchronously; the next op is accepted with 1-cycle latency.
